// File: rtl/int_img_pkg.sv
// int_img_pkg: frame geometry and value types shared by the downscaler, integral-image and vj_pipeline stages
package int_img_pkg;
  localparam int IMG_WIDTH  = 320;
  localparam int IMG_HEIGHT = 240;
  localparam int PIX_W      = 8;
  localparam int II_W       = 25;
  typedef logic [PIX_W-1:0]              pixel_t;
  typedef logic [II_W-1:0]               ii_t;
  typedef logic [$clog2(IMG_HEIGHT)-1:0] row_idx_t;
  typedef logic [$clog2(IMG_WIDTH)-1:0]  col_idx_t;
endpackage

// File: rtl/int_img_line_buf.sv
// int_img_line_buf: one row of integral values, combinational read, synchronous write, read-before-write
module int_img_line_buf #(
  parameter int DEPTH = int_img_pkg::IMG_WIDTH,
  parameter int DW    = int_img_pkg::II_W
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata
);
  logic [DW-1:0] mem [DEPTH];
  assign rdata = mem[addr];
  // Write lands at the clock edge, so a same-cycle read still sees the previous row
  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
  end
endmodule

// File: rtl/int_img_stream.sv
// int_img_stream: streaming integral image, one output per accepted pixel with one cycle of latency
module int_img_stream #(
  parameter int WIDTH  = int_img_pkg::IMG_WIDTH,
  parameter int HEIGHT = int_img_pkg::IMG_HEIGHT,
  parameter int PIX_W  = int_img_pkg::PIX_W,
  parameter int OUT_W  = int_img_pkg::II_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [PIX_W-1:0]          pix_in,
  input  logic                      pix_sof,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  output logic [OUT_W-1:0]          ii_out,
  output logic [$clog2(HEIGHT)-1:0] ii_row,
  output logic [$clog2(WIDTH)-1:0]  ii_col,
  output logic                      ii_last,
  output logic                      ii_valid,
  input  logic                      ii_ready,
  output logic                      frame_done
);
  import int_img_pkg::*;
  localparam int RW = $clog2(HEIGHT);
  localparam int CW = $clog2(WIDTH);
  logic [RW-1:0]    row, cur_r;
  logic [CW-1:0]    col, cur_c;
  logic [OUT_W-1:0] row_sum, rs, above, ii, lb_rd;
  logic             accept, col_end, at_last;
  assign pix_ready = !ii_valid || ii_ready;
  assign accept    = pix_valid && pix_ready;
  // Position of the incoming pixel (sof forces 0,0) and its integral value
  always_comb begin
    cur_r   = pix_sof ? '0 : row;
    cur_c   = pix_sof ? '0 : col;
    col_end = cur_c == CW'(WIDTH - 1);
    at_last = col_end && cur_r == RW'(HEIGHT - 1);
    rs      = (cur_c == '0 ? '0 : row_sum) + OUT_W'(pix_in);
    above   = cur_r == '0 ? '0 : lb_rd;
    ii      = rs + above;
  end
  int_img_line_buf #(.DEPTH(WIDTH), .DW(OUT_W)) u_line_buf (
    .clock (clock),
    .we    (accept),
    .addr  (cur_c),
    .wdata (ii),
    .rdata (lb_rd)
  );
  // Raster counters and running row sum advance only on an accepted pixel
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row     <= '0;
      col     <= '0;
      row_sum <= '0;
    end else if (accept) begin
      row_sum <= rs;
      col     <= col_end ? '0 : cur_c + 1'b1;
      row     <= at_last ? '0 : col_end ? cur_r + 1'b1 : cur_r;
    end
  end
  // Output register: reloads on accept, holds under backpressure, clears once consumed
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ii_valid   <= 1'b0;
      ii_out     <= '0;
      ii_row     <= '0;
      ii_col     <= '0;
      ii_last    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= ii_valid && ii_ready && ii_last;
      if (accept) begin
        ii_valid <= 1'b1;
        ii_out   <= ii;
        ii_row   <= cur_r;
        ii_col   <= cur_c;
        ii_last  <= at_last;
      end else if (ii_ready) begin
        ii_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_int_img_stream.sv
// tb_int_img_stream: directed checks on a 4x3 instance and one full-size frame on a default instance
module tb_int_img_stream;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [7:0]  s_pix = '0, b_pix = '0;
  logic        s_sof = 1'b0, s_valid = 1'b0, s_ii_ready = 1'b1, s_ready, s_last, s_ii_valid, s_done;
  logic        b_sof = 1'b0, b_valid = 1'b0, b_ii_ready = 1'b1, b_ready, b_last, b_ii_valid, b_done;
  logic [24:0] s_out, b_out;
  logic [1:0]  s_row, s_col;
  logic [7:0]  b_row;
  logic [8:0]  b_col;
  int tests = 0;
  int fails = 0;
  int ramp_exp [12] = '{0, 1, 3, 6, 4, 10, 18, 28, 12, 27, 45, 66};

  int_img_stream #(.WIDTH(4), .HEIGHT(3)) u_small (
    .clock(clock), .reset(reset), .pix_in(s_pix), .pix_sof(s_sof), .pix_valid(s_valid),
    .pix_ready(s_ready), .ii_out(s_out), .ii_row(s_row), .ii_col(s_col), .ii_last(s_last),
    .ii_valid(s_ii_valid), .ii_ready(s_ii_ready), .frame_done(s_done)
  );

  int_img_stream u_big (
    .clock(clock), .reset(reset), .pix_in(b_pix), .pix_sof(b_sof), .pix_valid(b_valid),
    .pix_ready(b_ready), .ii_out(b_out), .ii_row(b_row), .ii_col(b_col), .ii_last(b_last),
    .ii_valid(b_ii_valid), .ii_ready(b_ii_ready), .frame_done(b_done)
  );

  task automatic s_send(input logic [7:0] p, input logic sof);
    s_pix = p;
    s_sof = sof;
    s_valid = 1'b1;
    @(posedge clock); #1;
    s_valid = 1'b0;
    s_sof = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    tests++;
    if (s_ii_valid !== 1'b0 || s_out !== '0 || s_row !== '0 || s_col !== '0 || s_last !== 1'b0 ||
        s_done !== 1'b0 || s_ready !== 1'b1 || b_ii_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset: v=%b out=%0d row=%0d col=%0d last=%b done=%b rdy=%b bv=%b, want all 0 and rdy=1",
               s_ii_valid, s_out, s_row, s_col, s_last, s_done, s_ready, b_ii_valid);
    end
    reset = 1'b0;
  endtask

  task automatic test_ones();
    for (int i = 0; i < 12; i++) begin
      s_send(8'd1, i == 0);
      tests++;
      if (s_ii_valid !== 1'b1 || s_out !== 25'((i/4+1)*(i%4+1)) || s_row !== 2'(i/4) ||
          s_col !== 2'(i%4) || s_last !== (i == 11) || s_done !== 1'b0) begin
        fails++;
        $display("FAIL ones[%0d]: v=%b out=%0d row=%0d col=%0d last=%b done=%b, want out=%0d row=%0d col=%0d last=%b",
                 i, s_ii_valid, s_out, s_row, s_col, s_last, s_done, (i/4+1)*(i%4+1), i/4, i%4, i == 11);
      end
    end
    @(posedge clock); #1;
    tests++;
    if (s_done !== 1'b1 || s_ii_valid !== 1'b0) begin
      fails++;
      $display("FAIL ones_done: done=%b v=%b, want done=1 v=0", s_done, s_ii_valid);
    end
    @(posedge clock); #1;
    tests++;
    if (s_done !== 1'b0) begin
      fails++;
      $display("FAIL ones_done_pulse: done=%b, want 0", s_done);
    end
  endtask

  task automatic test_ramp();
    for (int i = 0; i < 12; i++) begin
      s_send(8'(i), 1'b0);
      tests++;
      if (s_ii_valid !== 1'b1 || s_out !== 25'(ramp_exp[i]) || s_last !== (i == 11)) begin
        fails++;
        $display("FAIL ramp[%0d]: v=%b out=%0d last=%b, want out=%0d last=%b",
                 i, s_ii_valid, s_out, s_last, ramp_exp[i], i == 11);
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic test_stall();
    int idx_in = 0;
    int idx_out = 0;
    int n = 0;
    logic held = 1'b0;
    logic [24:0] h_out = '0;
    logic [1:0] h_row = '0, h_col = '0;
    while (idx_out < 12 && n < 400) begin
      if (held) begin
        tests++;
        if (s_ii_valid !== 1'b1 || s_out !== h_out || s_row !== h_row || s_col !== h_col) begin
          fails++;
          $display("FAIL stall_hold: v=%b out=%0d row=%0d col=%0d, want v=1 out=%0d row=%0d col=%0d",
                   s_ii_valid, s_out, s_row, s_col, h_out, h_row, h_col);
        end
      end
      s_valid = (idx_in < 12) && ($urandom_range(0, 1) == 1);
      s_pix = 8'(idx_in);
      s_ii_ready = $urandom_range(0, 1) == 1;
      #1;
      tests++;
      if (s_ready !== (!s_ii_valid || s_ii_ready)) begin
        fails++;
        $display("FAIL stall_ready: rdy=%b, want %b", s_ready, !s_ii_valid || s_ii_ready);
      end
      held = s_ii_valid && !s_ii_ready;
      h_out = s_out;
      h_row = s_row;
      h_col = s_col;
      if (s_ii_valid && s_ii_ready) begin
        tests++;
        if (s_out !== 25'(ramp_exp[idx_out]) || s_row !== 2'(idx_out/4) || s_col !== 2'(idx_out%4) ||
            s_last !== (idx_out == 11)) begin
          fails++;
          $display("FAIL stall_beat[%0d]: out=%0d row=%0d col=%0d last=%b, want out=%0d row=%0d col=%0d",
                   idx_out, s_out, s_row, s_col, s_last, ramp_exp[idx_out], idx_out/4, idx_out%4);
        end
        idx_out++;
      end
      if (s_valid && s_ready) idx_in++;
      @(posedge clock); #1;
      n++;
    end
    s_valid = 1'b0;
    s_ii_ready = 1'b1;
    tests++;
    if (idx_out != 12 || s_done !== 1'b1 || s_ii_valid !== 1'b0) begin
      fails++;
      $display("FAIL stall_end: beats=%0d done=%b v=%b, want beats=12 done=1 v=0", idx_out, s_done, s_ii_valid);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_sof();
    for (int i = 0; i < 18; i++) begin
      int j = i < 6 ? i : i - 6;
      s_send(8'd1, i == 6);
      tests++;
      if (s_ii_valid !== 1'b1 || s_out !== 25'((j/4+1)*(j%4+1)) || s_row !== 2'(j/4) || s_col !== 2'(j%4)) begin
        fails++;
        $display("FAIL sof[%0d]: out=%0d row=%0d col=%0d, want out=%0d row=%0d col=%0d",
                 i, s_out, s_row, s_col, (j/4+1)*(j%4+1), j/4, j%4);
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 6; i++) s_send(8'd1, i == 0);
    tests++;
    if (s_ii_valid !== 1'b1 || s_out !== 25'd4) begin
      fails++;
      $display("FAIL mid_pre: v=%b out=%0d, want v=1 out=4", s_ii_valid, s_out);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (s_ii_valid !== 1'b0 || s_out !== '0 || s_row !== '0 || s_col !== '0 || s_last !== 1'b0 || s_done !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: v=%b out=%0d row=%0d col=%0d last=%b done=%b, want all 0",
               s_ii_valid, s_out, s_row, s_col, s_last, s_done);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      s_send(8'd1, 1'b0);
      tests++;
      if (s_out !== 25'((i/4+1)*(i%4+1)) || s_row !== 2'(i/4) || s_col !== 2'(i%4)) begin
        fails++;
        $display("FAIL after_reset[%0d]: out=%0d row=%0d col=%0d, want out=%0d row=%0d col=%0d",
                 i, s_out, s_row, s_col, (i/4+1)*(i%4+1), i/4, i%4);
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      int k = i % 12;
      s_send(8'd255, i == 0);
      tests++;
      if (s_out !== 25'(255*(k/4+1)*(k%4+1)) || s_last !== (k == 11)) begin
        fails++;
        $display("FAIL b2b[%0d]: out=%0d last=%b, want out=%0d last=%b", i, s_out, s_last, 255*(k/4+1)*(k%4+1), k == 11);
      end
    end
    @(posedge clock); #1;
    tests++;
    if (s_done !== 1'b1) begin
      fails++;
      $display("FAIL b2b_done: done=%b, want 1", s_done);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 76800; i++) begin
      b_pix = 8'd255;
      b_sof = i == 0;
      b_valid = 1'b1;
      @(posedge clock); #1;
      if (i == 319 || i == 320 || i == 76799) begin
        int ev = i == 319 ? 81600 : i == 320 ? 510 : 19584000;
        tests++;
        if (b_out !== 25'(ev) || b_row !== 8'(i/320) || b_col !== 9'(i%320) || b_last !== (i == 76799)) begin
          fails++;
          $display("FAIL full[%0d]: out=%0d row=%0d col=%0d last=%b, want out=%0d row=%0d col=%0d",
                   i, b_out, b_row, b_col, b_last, ev, i/320, i%320);
        end
      end
    end
    b_valid = 1'b0;
    b_sof = 1'b0;
    @(posedge clock); #1;
    tests++;
    if (b_done !== 1'b1 || b_ii_valid !== 1'b0) begin
      fails++;
      $display("FAIL full_done: done=%b v=%b, want done=1 v=0", b_done, b_ii_valid);
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_ramp();
    test_stall();
    test_sof();
    test_mid_reset();
    test_back_to_back();
    test_full();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/int_img_stream.md
Name: int_img_stream

Overview:
- Streaming integral-image calculator; sits between the per-scale downscaler stage and the scanning-window / vj_pipeline stage.
- Accepts 8-bit grayscale pixels in raster order over a valid/ready handshake.
- Emits one integral-image value per pixel, in the same raster order: ii[r][c] = sum of pix[y][x] for y<=r, x<=c.
- Replaces the whole-frame combinational int_img_calc with one row of storage plus two accumulators.

Parameters:
WIDTH, 320, pixels per row
HEIGHT, 240, rows per frame
PIX_W, 8, input pixel width
OUT_W, 25, integral value width; must satisfy (2^PIX_W-1)*WIDTH*HEIGHT < 2^OUT_W (255*76800 = 19,584,000 < 2^25)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
pix_in  in  PIX_W  input pixel
pix_sof  in  1  qualifies pix_in as pixel (0,0) of a frame
pix_valid  in  1  pix_in/pix_sof valid
pix_ready  out  1  block accepts pixel this cycle
ii_out  out  OUT_W  integral value
ii_row  out  $clog2(HEIGHT)  row of ii_out
ii_col  out  $clog2(WIDTH)  column of ii_out
ii_last  out  1  ii_out is pixel (HEIGHT-1, WIDTH-1)
ii_valid  out  1  output valid
ii_ready  in  1  downstream accepts output
frame_done  out  1  one-cycle pulse after the last pixel's output is accepted

Behaviour:
- Reset (async): ii_valid=0, ii_out=0, ii_row=0, ii_col=0, ii_last=0, frame_done=0, row/col counters=0, row_sum=0. Line-buffer contents are don't-care and are not cleared.
- Handshake:
  - Accept when pix_valid && pix_ready.
  - Emit when ii_valid && ii_ready.
  - pix_ready = !ii_valid || ii_ready; combinational path from ii_ready only.
  - ii_out/ii_row/ii_col/ii_last hold stable while ii_valid && !ii_ready.
  - ii_valid never drops without acceptance.
- Latency: exactly 1 cycle. A pixel accepted in cycle N has its result on ii_out with ii_valid=1 in cycle N+1. Full throughput of 1 pixel/cycle while ii_ready=1.
- Arithmetic on accept at (r,c):
  - rs = (c==0 ? 0 : row_sum) + pix_in.
  - above = (r==0 ? 0 : lb[c]).
  - ii = rs + above, zero-extended to OUT_W. No saturation; the width rule guarantees no overflow.
  - Write lb[c] <= ii; row_sum <= rs.
  - Read and write of lb[c] occur in the same accept cycle. The read returns the old (previous-row) value: read-before-write.
- Counters (advance on accept only):
  - col increments; at WIDTH-1 it wraps to 0 and row increments.
  - At (HEIGHT-1, WIDTH-1) both wrap to 0.
- pix_sof:
  - If accepted with pix_sof=1, the pixel is treated as (0,0) regardless of the counters. Counters and row_sum resync; this is the mid-frame resync path.
  - pix_sof=1 at (0,0) is a no-op.
  - pix_sof=0 at expected (0,0) is still processed as (0,0); sof is not required.
- ii_last = 1 on the output beat for (HEIGHT-1, WIDTH-1).
- frame_done = 1 for the one cycle following acceptance of the ii_last beat.
- Simultaneous events: accept and emit in the same cycle is legal. The output register reloads with the new pixel and ii_valid stays 1.
- Reset mid-frame: all state returns to reset values immediately. The next accepted pixel is (0,0). An in-flight output is discarded.

Decomposition:
- Package int_img_pkg holds:
  - localparams IMG_WIDTH=320, IMG_HEIGHT=240, PIX_W=8, II_W=25.
  - typedefs pixel_t, ii_t, row_idx_t, col_idx_t.
  - These are shared with the downscaler stage and vj_pipeline.
- Sub-module int_img_line_buf:
  - WIDTH x OUT_W, single-port, combinational read, synchronous write, read-before-write.
  - Isolated so it can map to BRAM later; a registered-read variant then needs one extra pipeline stage.

Test Plan:
- WIDTH=4, HEIGHT=3, all pixels 1, ii_ready=1 -> outputs (r+1)*(c+1) in raster order, 1-cycle latency; ii_last only on value 12; frame_done pulses once, one cycle later.
- WIDTH=4, HEIGHT=3, pix = r*4+c -> row0 = 0,1,3,6; row1 = 4,10,18,28; row2 = 12,27,45,66.
- Default parameters, all pixels 255 -> final ii_out = 19,584,000 with no wrap; second frame back-to-back repeats identical values with no stale line-buffer effect on row 0.
- Random ii_ready (about 50% low) and random pix_valid on the 4x3 ramp frame -> same value sequence as the ramp test, no drops or duplicates, outputs stable during stalls, pix_ready low exactly when ii_valid && !ii_ready.
- 4x3 all-ones frame, pix_sof=1 asserted at pixel (1,2) -> that pixel outputs 1 and the following pixels are (0,1)=2, (0,2)=3, etc.
- Reset asserted mid-frame at (1,1) with ii_valid=1 -> ii_valid=0 immediately, all outputs 0; the next frame of all ones yields the correct 1,2,3,4 first row.
